ucsbece154a_rf_wb_arbiter: RTL

Shares the register file's single write port (we3/a3/wd3) between two writeback requesters: the main pipeline writeback stage (port 0) and the multicycle execution unit (port 1). Arbitrates with valid/ready handshakes and drives a registered write request into the register file. Keeps a 32-bit pending-write scoreboard so decode can stall on registers still owed a result by the multicycle unit.

---
 rtl/ucsbece154a_rf_pkg.sv | 11 +
 rtl/ucsbece154a_rf_scoreboard.sv | 44 ++++
 rtl/ucsbece154a_rf_wb_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/ucsbece154a_rf_pkg.sv
// Shared widths, register/port constants for the register-file writeback arbiter.
package ucsbece154a_rf_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 1 << REG_W;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  localparam logic PORT_WB = 1'b0;
  localparam logic PORT_MC = 1'b1;
endpackage

// File: rtl/ucsbece154a_rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register owed a result by the multicycle unit.
module ucsbece154a_rf_scoreboard
  import ucsbece154a_rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              alloc_i,
  input  logic [REG_W-1:0]  alloc_rd_i,
  input  logic              clr_i,
  input  logic [REG_W-1:0]  clr_rd_i,
  output logic [NREG-1:0]   busy_o,
  output logic              err_o
);

  logic            set_en;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear so a same-register collision leaves the bit set.
  always_comb begin
    set_en   = alloc_i && (alloc_rd_i != ZERO_REG);
    set_mask = '0;
    clr_mask = '0;
    if (set_en)
      set_mask[alloc_rd_i] = 1'b1;
    if (clr_i)
      clr_mask[clr_rd_i] = 1'b1;
    busy_d    = (busy_o & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_o <= '0;
      err_o  <= 1'b0;
    end else begin
      busy_o <= busy_d;
      if (set_en && busy_o[alloc_rd_i])
        err_o <= 1'b1;
    end
  end

endmodule

// File: rtl/ucsbece154a_rf_wb_arbiter.sv
// Arbitrates the register file's single write port between the writeback stage
// and the multicycle unit, and tracks registers still owed a multicycle result.
module ucsbece154a_rf_wb_arbiter
  import ucsbece154a_rf_pkg::*;
#(
  parameter int RR_EN      = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              wb0_valid_i,
  output logic              wb0_ready_o,
  input  logic [REG_W-1:0]  wb0_rd_i,
  input  logic [DATA_W-1:0] wb0_data_i,
  input  logic              wb1_valid_i,
  output logic              wb1_ready_o,
  input  logic [REG_W-1:0]  wb1_rd_i,
  input  logic [DATA_W-1:0] wb1_data_i,
  input  logic              alloc_i,
  input  logic [REG_W-1:0]  alloc_rd_i,
  output logic [NREG-1:0]   busy_o,
  output logic              err_o,
  output logic              rf_we3_o,
  output logic [REG_W-1:0]  rf_a3_o,
  output logic [DATA_W-1:0] rf_wd3_o
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic              last_grant;
  logic [CNT_W-1:0]  starve_cnt;
  logic              src_p1;
  logic              pick_mc;
  logic              gnt0;
  logic              gnt1;
  logic              xfer;
  logic [REG_W-1:0]  sel_rd;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    pick_mc = wb1_valid_i;
    if (wb0_valid_i && wb1_valid_i)
      pick_mc = (RR_EN != 0) ? (last_grant == PORT_WB) : (starve_cnt == STARVE_LIM);
    gnt0     = rst_n_i && wb0_valid_i && !pick_mc;
    gnt1     = rst_n_i && wb1_valid_i && pick_mc;
    xfer     = gnt0 || gnt1;
    sel_rd   = gnt1 ? wb1_rd_i   : wb0_rd_i;
    sel_data = gnt1 ? wb1_data_i : wb0_data_i;
  end

  assign wb0_ready_o = gnt0;
  assign wb1_ready_o = gnt1;

  // Stage p1: registered register-file write request plus its source port.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_grant <= PORT_MC;
      starve_cnt <= '0;
      src_p1     <= PORT_WB;
      rf_we3_o   <= 1'b0;
      rf_a3_o    <= '0;
      rf_wd3_o   <= '0;
    end else begin
      if (xfer)
        last_grant <= gnt1 ? PORT_MC : PORT_WB;
      if (!wb1_valid_i || gnt1)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 1'b1;
      rf_we3_o <= xfer && (sel_rd != ZERO_REG);
      src_p1   <= gnt1 ? PORT_MC : PORT_WB;
      if (xfer) begin
        rf_a3_o  <= sel_rd;
        rf_wd3_o <= sel_data;
      end
    end
  end

  ucsbece154a_rf_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n_i    (rst_n_i),
    .alloc_i    (alloc_i),
    .alloc_rd_i (alloc_rd_i),
    .clr_i      (rf_we3_o && (src_p1 == PORT_MC)),
    .clr_rd_i   (rf_a3_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

endmodule
